// File: rtl/stdp_weight_updater.sv
// stdp_weight_updater: FIFO-buffered, serialized, clamped read-modify-write of a 256-entry synaptic weight store.
// Optional power-up sweep of W_INIT into every entry is enabled by defining STDP_WEIGHT_INIT_EN.
module stdp_weight_updater #(
  parameter logic [7:0] W_MIN = 8'd0,
  parameter logic [7:0] W_MAX = 8'd255,
  parameter logic [7:0] W_INIT = 8'd128,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        upd_valid,
  input  logic [7:0]  upd_addr,
  input  logic [7:0]  upd_delta,
  output logic        upd_ready,
  input  logic [7:0]  rd_addr,
  output logic [7:0]  rd_data,
  output logic        done_valid,
  output logic [7:0]  done_addr,
  output logic [7:0]  done_weight,
  output logic        busy,
  output logic [31:0] update_count,
  output logic [31:0] sat_hi_count,
  output logic [31:0] sat_lo_count,
  output logic [31:0] drop_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {INIT, IDLE, READ, WRITE} state_t;
`ifdef STDP_WEIGHT_INIT_EN
  localparam state_t RST_STATE = INIT;
`else
  localparam state_t RST_STATE = IDLE;
`endif
  state_t state, state_nx;
  logic [7:0] mem [256];
  logic [7:0] fifo_addr [FIFO_DEPTH];
  logic [7:0] fifo_delta [FIFO_DEPTH];
  logic [AW:0] wp, rp;
  logic [7:0] addr_r, delta_r, w_r, init_cnt, new_w;
  logic fifo_full, fifo_empty, push, pop, sat_hi, sat_lo;
  logic signed [9:0] sum;
  assign fifo_empty = wp == rp;
  assign fifo_full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  always_ff @(posedge clk)
    if (rst) state <= RST_STATE;
    else state <= state_nx;
  always_comb begin
    state_nx = (state == INIT) ? ((init_cnt == 8'hff) ? IDLE : INIT) :
               (state == IDLE) ? (fifo_empty ? IDLE : READ) :
               (state == READ) ? WRITE : IDLE;
  end
  always_comb begin
    upd_ready = !fifo_full && state != INIT;
    busy = !fifo_empty || state != IDLE;
    push = upd_valid && upd_ready;
    pop = state == IDLE && !fifo_empty;
  end
  // 10-bit signed sum covers -128..382 so both clamp directions are exact
  assign sum = $signed({2'b00, w_r}) + $signed({{2{delta_r[7]}}, delta_r});
  assign sat_hi = sum > $signed({2'b00, W_MAX});
  assign sat_lo = sum < $signed({2'b00, W_MIN});
  assign new_w = sat_hi ? W_MAX : sat_lo ? W_MIN : sum[7:0];
`ifdef STDP_WEIGHT_INIT_EN
  always_ff @(posedge clk)
    if (rst) init_cnt <= 8'd0;
    else if (state == INIT) init_cnt <= init_cnt + 8'd1;
`else
  assign init_cnt = 8'd0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
    end
    if (push) begin
      fifo_addr[wp[AW-1:0]] <= upd_addr;
      fifo_delta[wp[AW-1:0]] <= upd_delta;
    end
  end
  always_ff @(posedge clk) begin
    if (pop) begin
      addr_r <= fifo_addr[rp[AW-1:0]];
      delta_r <= fifo_delta[rp[AW-1:0]];
    end
    if (state == READ) w_r <= mem[addr_r];
  end
  // reset suppresses any in-flight write; the array itself is never cleared by reset
  always_ff @(posedge clk) begin
    if (!rst && state == INIT) mem[init_cnt] <= W_INIT;
    if (!rst && state == WRITE) mem[addr_r] <= new_w;
    rd_data <= rst ? 8'd0 : mem[rd_addr];
  end
  always_ff @(posedge clk)
    if (rst) begin
      done_valid <= 1'b0;
      done_addr <= 8'd0;
      done_weight <= 8'd0;
      update_count <= 32'd0;
      sat_hi_count <= 32'd0;
      sat_lo_count <= 32'd0;
      drop_count <= 32'd0;
    end else begin
      done_valid <= state == WRITE;
      if (state == WRITE) begin
        done_addr <= addr_r;
        done_weight <= new_w;
        update_count <= update_count + 32'd1;
        if (sat_hi) sat_hi_count <= sat_hi_count + 32'd1;
        if (sat_lo) sat_lo_count <= sat_lo_count + 32'd1;
      end
      if (upd_valid && !upd_ready) drop_count <= drop_count + 32'd1;
    end
endmodule
